// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped I/O window: input sync/change flags, output latch, 4-deep TX FIFO, reload timer
module mmio_responder #(
    parameter logic [3:0] BASE = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       memWrite,
    output logic [7:0] rdata,
    output logic       sel,
    output logic       memWe,
    input  logic [7:0] inputPort,
    output logic [7:0] outputPort,
    output logic [7:0] txData,
    output logic       txValid,
    input  logic       txReady
);
    logic [3:0] offset;
    logic       wrEn;
    logic       wrInChg, wrOut, wrTx, wrStatus, wrReload;

    logic [7:0] syncA, syncB, inChg, outReg;
    logic [7:0] fifoMem [4];
    logic [1:0] rdPtr, wrPtr;
    logic [2:0] count;
    logic       ovf, tmr;
    logic [7:0] reload, tmrCount;

    logic       full, empty, pop, push, ovfSet, tmrSet;
    logic [7:0] status;

    assign offset   = addr[3:0];
    assign sel      = (addr[7:4] == BASE);
    assign memWe    = memWrite & ~sel;
    assign wrEn     = sel & memWrite;
    assign wrInChg  = wrEn && (offset == 4'h1);
    assign wrOut    = wrEn && (offset == 4'h2);
    assign wrTx     = wrEn && (offset == 4'h3);
    assign wrStatus = wrEn && (offset == 4'h4);
    assign wrReload = wrEn && (offset == 4'h5);

    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign pop     = ~empty & txReady;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push    = wrTx && (~full || pop);
    assign ovfSet  = wrTx && full && ~pop;
    assign tmrSet  = ~wrReload && (reload != 8'd0) && (tmrCount == 8'd1);

    assign txValid    = ~empty;
    assign txData     = empty ? 8'h00 : fifoMem[rdPtr];
    assign outputPort = outReg;
    assign status     = {1'b0, count, tmr, ovf, full, empty};

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (offset)
                4'h0:    rdata = syncB;
                4'h1:    rdata = inChg;
                4'h2:    rdata = outReg;
                4'h4:    rdata = status;
                4'h5:    rdata = reload;
                4'h6:    rdata = tmrCount;
                default: rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncA <= 8'h00;
            syncB <= 8'h00;
            inChg <= 8'h00;
            outReg <= 8'h00;
        end else begin
            syncA <= inputPort;
            syncB <= syncA;
            // Change detect compares the sample entering stage two against its current value.
            inChg <= (syncA ^ syncB) | (inChg & ~(wrInChg ? wdata : 8'h00));
            if (wrOut)
                outReg <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifoMem[wrPtr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= 2'd0;
            wrPtr <= 2'd0;
            count <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wrPtr <= wrPtr + 2'd1;
            if (pop)
                rdPtr <= rdPtr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            ovf <= ovfSet | (ovf & ~(wrStatus & wdata[2]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload   <= 8'h00;
            tmrCount <= 8'h00;
            tmr      <= 1'b0;
        end else begin
            if (wrReload) begin
                reload   <= wdata;
                tmrCount <= wdata;
            end else if (reload != 8'd0) begin
                tmrCount <= (tmrCount > 8'd1) ? tmrCount - 8'd1 : reload;
            end
            tmr <= tmrSet | (tmr & ~(wrStatus & wdata[3]));
        end
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - scoreboard bench: directed register scenarios plus randomized bus traffic
module tb_mmio_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       memWrite = 1'b0;
    logic [7:0] rdata;
    logic       sel;
    logic       memWe;
    logic [7:0] inputPort = 8'h00;
    logic [7:0] outputPort;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady = 1'b0;

    int total = 0;
    int bad = 0;

    logic [7:0] expQ [$];
    logic [7:0] mOut = 8'h00;
    logic       mOvf = 1'b0;

    mmio_responder #(.BASE(4'hF)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .memWrite(memWrite),
        .rdata(rdata), .sel(sel), .memWe(memWe), .inputPort(inputPort),
        .outputPort(outputPort), .txData(txData), .txValid(txValid), .txReady(txReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expStatus();
        logic [2:0] sz;
        sz = 3'(expQ.size());
        return {1'b0, sz, 1'b0, mOvf, sz == 3'd4, sz == 3'd0};
    endfunction

    // Reference model: bytes accepted while fewer than four are held after this edge's pop.
    always @(posedge clk) begin
        if (rst && memWrite && addr[7:4] == 4'hF) begin
            case (addr[3:0])
                4'h2: mOut = wdata;
                4'h3: if (expQ.size() < 4) expQ.push_back(wdata); else mOvf = 1'b1;
                4'h4: if (wdata[2]) mOvf = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                chk("txValid", {7'b0, txValid}, {7'b0, expQ.size() != 0});
                if (txValid && expQ.size() != 0) begin
                    chk("txData", txData, expQ[0]);
                    if (txReady)
                        void'(expQ.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w, input logic rdy);
        @(negedge clk);
        addr = a;
        wdata = d;
        memWrite = w;
        txReady = rdy;
        #1;
        chk("memWe", {7'b0, memWe}, {7'b0, w & (a[7:4] != 4'hF)});
        chk("sel", {7'b0, sel}, {7'b0, a[7:4] == 4'hF});
        chk("outputPort", outputPort, mOut);
    endtask

    initial begin
        logic [7:0] a, d;
        logic [7:0] cntExp [4];
        int op;
        logic rdy;
        cntExp[0] = 8'd3; cntExp[1] = 8'd2; cntExp[2] = 8'd1; cntExp[3] = 8'd3;

        repeat (2) @(negedge clk);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0);
        chk("rst_status", rdata, 8'h01);
        chk("rst_txValid", {7'b0, txValid}, 8'h00);
        chk("rst_txData", txData, 8'h00);
        rst = 1'b1;
        cyc(8'hF6, 8'h00, 1'b0, 1'b0); chk("rst_count", rdata, 8'h00);
        cyc(8'hF5, 8'h00, 1'b0, 1'b0); chk("rst_reload", rdata, 8'h00);
        cyc(8'hF1, 8'h00, 1'b0, 1'b0); chk("rst_inchg", rdata, 8'h00);

        cyc(8'hF2, 8'hA5, 1'b1, 1'b0);
        cyc(8'hF2, 8'h00, 1'b0, 1'b0);
        chk("out_rd", rdata, 8'hA5);
        chk("out_port", outputPort, 8'hA5);
        cyc(8'h10, 8'h5A, 1'b1, 1'b0);
        chk("outside_rd", rdata, 8'h00);
        cyc(8'hF2, 8'h00, 1'b0, 1'b0);
        chk("out_kept", rdata, 8'hA5);

        inputPort = 8'h81;
        cyc(8'hF0, 8'h00, 1'b0, 1'b0); chk("in_lat1", rdata, 8'h00);
        cyc(8'hF0, 8'h00, 1'b0, 1'b0); chk("in_lat2", rdata, 8'h81);
        cyc(8'hF1, 8'h00, 1'b0, 1'b0); chk("inchg_set", rdata, 8'h81);
        cyc(8'hF1, 8'h01, 1'b1, 1'b0);
        cyc(8'hF1, 8'h00, 1'b0, 1'b0); chk("inchg_w1c", rdata, 8'h80);
        cyc(8'hF1, 8'hFF, 1'b1, 1'b0);

        for (int i = 1; i <= 5; i++)
            cyc(8'hF3, 8'(i * 8'h11), 1'b1, 1'b0);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("status_full_ovf", rdata, 8'h46);
        repeat (5) cyc(8'hF4, 8'h00, 1'b0, 1'b1);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("status_empty_ovf", rdata, 8'h05);
        cyc(8'hF4, 8'h04, 1'b1, 1'b0);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("ovf_w1c", rdata, 8'h01);

        for (int i = 1; i <= 4; i++)
            cyc(8'hF3, 8'(8'hA0 + i), 1'b1, 1'b0);
        cyc(8'hF3, 8'h66, 1'b1, 1'b1);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("pushpop_full", rdata, 8'h42);
        repeat (4) cyc(8'hF4, 8'h00, 1'b0, 1'b1);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("pushpop_drain", rdata, 8'h01);

        cyc(8'hF5, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(8'hF6, 8'h00, 1'b0, 1'b0);
            chk("timer_count", rdata, cntExp[i]);
        end
        cyc(8'hF4, 8'h08, 1'b1, 1'b0);
        cyc(8'hF4, 8'h08, 1'b1, 1'b0); chk("tmr_cleared", {7'b0, rdata[3]}, 8'h00);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("tmr_set_wins", {7'b0, rdata[3]}, 8'h01);
        cyc(8'hF6, 8'h00, 1'b0, 1'b0); chk("timer_after", rdata, 8'h02);
        cyc(8'hF5, 8'h00, 1'b0, 1'b0); chk("reload_rd", rdata, 8'h03);
        cyc(8'hF5, 8'h00, 1'b1, 1'b0);
        cyc(8'hF4, 8'h08, 1'b1, 1'b0);
        cyc(8'hF6, 8'h00, 1'b0, 1'b0); chk("timer_off", rdata, 8'h00);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("tmr_off", rdata, 8'h01);

        cyc(8'hF2, 8'h3C, 1'b1, 1'b0);
        cyc(8'hF3, 8'hB1, 1'b1, 1'b0);
        cyc(8'hF3, 8'hB2, 1'b1, 1'b0);
        cyc(8'hF4, 8'h00, 1'b0, 1'b0); chk("pre_rst_status", rdata, 8'h20);
        @(negedge clk);
        rst = 1'b0;
        memWrite = 1'b0;
        addr = 8'hF4;
        #1;
        chk("arst_txValid", {7'b0, txValid}, 8'h00);
        chk("arst_outputPort", outputPort, 8'h00);
        chk("arst_status", rdata, 8'h01);
        chk("arst_txData", txData, 8'h00);
        expQ.delete();
        mOut = 8'h00;
        mOvf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(8'hF1, 8'h00, 1'b0, 1'b0); chk("post_rst_inchg0", rdata, 8'h00);
        cyc(8'hF1, 8'h00, 1'b0, 1'b0); chk("post_rst_inchg", rdata, 8'h81);
        cyc(8'hF1, 8'hFF, 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            rdy = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            case (op)
                0, 1, 2: cyc(8'hF3, d, 1'b1, rdy);
                3: cyc(8'hF2, d, 1'b1, rdy);
                4: cyc(8'hF4, d & 8'hF7, 1'b1, rdy);
                5: begin
                    a = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
                    cyc(a, d, 1'b1, rdy);
                    chk("rnd_outside", rdata, 8'h00);
                end
                6: begin
                    cyc(8'hF4, 8'h00, 1'b0, rdy);
                    chk("rnd_status", rdata, expStatus());
                end
                7: begin
                    cyc(8'hF2, 8'h00, 1'b0, rdy);
                    chk("rnd_out", rdata, mOut);
                end
                8: begin
                    a = {4'hF, 4'($urandom_range(7, 15))};
                    cyc(a, d, 1'($urandom_range(0, 1)), rdy);
                    chk("rnd_reserved", rdata, 8'h00);
                end
                default: begin
                    cyc(8'hF0, 8'h00, 1'b0, rdy);
                    chk("rnd_in", rdata, 8'h81);
                end
            endcase
        end

        repeat (6) cyc(8'hF4, 8'h00, 1'b0, 1'b1);
        chk("final_status", rdata, expStatus());
        chk("final_txValid", {7'b0, txValid}, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter: BASE, default 4'hF, upper address nibble that selects this block (window BASE0..BASEF).
REQ-002 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 addr  input  8  CPU data-bus address (toDataMemoryAddress side).
REQ-006 wdata  input  8  CPU write data.
REQ-007 memWrite  input  1  CPU write strobe, one cycle per store.
REQ-008 rdata  output  8  read data to CPU; combinational from addr and registers.
REQ-009 sel  output  1  high when addr[7:4]==BASE; CPU bus mux selects rdata over data memory.
REQ-010 memWe  output  1  memWrite & ~sel; gated write enable to data memory.
REQ-011 inputPort  input  8  asynchronous external switches.
REQ-012 outputPort  output  8  output register contents.
REQ-013 txData  output  8  FIFO head byte to external consumer.
REQ-014 txValid  output  1  FIFO not empty.
REQ-015 txReady  input  1  consumer accepts head when txValid & txReady at the rising edge.

Function
REQ-016 Register map (offset = addr[3:0]): 0 IN (RO), 1 INCHG (R/W1C), 2 OUT (R/W), 3 TXDATA (WO, reads 0x00), 4 STATUS (R, W1C bits 2-3), 5 RELOAD (R/W), 6 COUNT (RO), 7-F reserved (read 0x00, writes ignored).
REQ-017 Writes take effect only when sel & memWrite at the rising edge; reads have no side effects.
REQ-018 IN: inputPort through a 2-flop synchronizer; IN reads the second stage, so latency is 2 cycles.
REQ-019 INCHG bit n sets when synchronized bit n differs from its value one cycle earlier; a written 1 clears the bit; set wins over clear in the same cycle.
REQ-020 OUT: write loads outputPort at the next edge; outputPort reads back via offset 2.
REQ-021 TX FIFO: 4 entries, 3-bit count 0..4; a write to TXDATA pushes wdata; a txValid & txReady handshake pops the head; txData = head entry.
REQ-022 Push when count==4 and no pop: byte dropped, STATUS.ovf set, contents unchanged.
REQ-023 Push and pop in the same cycle when count==4: both occur, count stays 4, ovf not set.
REQ-024 Push when count==0: txValid rises the next cycle with txData=wdata; no same-cycle bypass.
REQ-025 Read and write pointers wrap modulo 4.
REQ-026 STATUS: bit0 empty, bit1 full, bit2 ovf (sticky), bit3 tmr (sticky), bits6:4 count, bit7 0; writing 1 to bit2/bit3 clears it; set wins over clear.
REQ-027 Timer: writing RELOAD=R loads COUNT=R at the same edge; with R==0 COUNT holds 0 and tmr never sets.
REQ-028 With R!=0: COUNT>1 decrements; COUNT==1 reloads R and sets tmr, so the period is R cycles.
REQ-029 Addresses outside the window: sel=0, rdata=0x00, no register changes, memWe=memWrite.

Reset
REQ-030 rst low asynchronously clears synchronizer, INCHG, OUT, FIFO pointers, count, ovf, tmr, RELOAD, and COUNT to 0; outputPort=0x00, txValid=0, txData=0x00.
REQ-031 Reset mid-handshake discards all FIFO contents; txValid falls immediately, not at the next edge.
REQ-032 After rst rises, the first synchronized sample produces no INCHG bits; the synchronizer resets to 0 and changes are counted from that value.

Verification
REQ-033 addr=0xF2, wdata=0xA5, memWrite=1 for 1 cycle -> outputPort=0xA5 next edge, memWe=0, read 0xF2=0xA5; addr=0x10 write -> memWe=1, outputPort unchanged.
REQ-034 inputPort 0x00->0x81 -> IN=0x81 after 2 edges, INCHG=0x81; write 0xF1=0x01 -> INCHG=0x80.
REQ-035 txReady=0, push 0x11,0x22,0x33,0x44,0x55 -> STATUS=0x46 (count4, full, ovf); then txReady=1 -> txData 0x11,0x22,0x33,0x44 on consecutive cycles, then txValid=0, STATUS=0x05 (empty, ovf).
REQ-036 FIFO full, push 0x66 with txReady=1 in the same cycle -> count stays 4, ovf clear, 0x66 emerges 4th after the pop.
REQ-037 RELOAD=3 -> tmr sets every 3 cycles (COUNT 3,2,1,3...); write STATUS=0x08 on an expiry cycle -> tmr remains 1.
REQ-038 rst low with count=2 and txValid=1 -> txValid=0, outputPort=0x00, STATUS=0x01 immediately.
